banco_registros_op: RTL

Register bank plus operand-latch stage directly upstream of the ALU.
- Holds the architectural registers and reads two sources per issue.
- Registers OP_1, OP_2 and ALU_Sel toward the ALU with a valid/ready handshake.
- Accepts the ALU result back through a single write-back port, with same-cycle bypass.

---
 rtl/banco_registros_op_pkg.sv | 21 ++
 rtl/banco_registros_op_reg_array.sv | 42 ++++
 rtl/banco_registros_op.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/banco_registros_op_pkg.sv
// Shared widths, ALU opcodes and stage state encoding for the register-bank /
// operand-latch stage that feeds the ALU.
package banco_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned ADDR_W = 5;
    localparam int unsigned SEL_W  = 3;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b011;
    localparam logic [2:0] ALU_GT  = 3'b100;

    // Occupancy of the operand latch
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } op_state_e;

endpackage

// File: rtl/banco_registros_op_reg_array.sv
// Architectural register storage: two combinational read ports, one
// synchronous write port, entry 0 hard-wired to zero, async active-low clear.
// Ports:
//   clk, rst_n                 clock / async active-low clear
//   i_wr_en/i_wr_addr/i_wr_data synchronous write port
//   i_rd_addr1/o_rd_data1       read port 1
//   i_rd_addr2/o_rd_data2       read port 2
module reg_array #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic [ADDR_W-1:0] i_rd_addr1,
    output logic [DATA_W-1:0] o_rd_data1,
    input  logic [ADDR_W-1:0] i_rd_addr2,
    output logic [DATA_W-1:0] o_rd_data2
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];

    // Storage; register 0 is never written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en && (i_wr_addr != '0)) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    // Register 0 reads as zero regardless of storage contents
    assign o_rd_data1 = (i_rd_addr1 == '0) ? '0 : r_mem[i_rd_addr1];
    assign o_rd_data2 = (i_rd_addr2 == '0) ? '0 : r_mem[i_rd_addr2];

endmodule

// File: rtl/banco_registros_op.sv
// Register bank plus operand latch in front of the ALU.
// Ports:
//   clk, rst_n                     clock / async active-low reset
//   id_valid, id_ready             issue handshake (id_ready combinational)
//   rs1, rs2, use_imm, imm, sel_in issue payload
//   wr_en, wr_addr, wr_data        ALU result write-back (with same-cycle bypass)
//   OP_1, OP_2, ALU_Sel, op_valid  registered operation toward the ALU
//   ex_ready                       ALU consumes the operation this cycle
module banco_registros_op #(
    parameter int unsigned DATA_W = banco_pkg::DATA_W,
    parameter int unsigned ADDR_W = banco_pkg::ADDR_W,
    parameter int unsigned SEL_W  = banco_pkg::SEL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    output logic              id_ready,
    input  logic [ADDR_W-1:0] rs1,
    input  logic [ADDR_W-1:0] rs2,
    input  logic              use_imm,
    input  logic [DATA_W-1:0] imm,
    input  logic [SEL_W-1:0]  sel_in,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] OP_1,
    output logic [DATA_W-1:0] OP_2,
    output logic [SEL_W-1:0]  ALU_Sel,
    output logic              op_valid,
    input  logic              ex_ready
);

    import banco_pkg::*;

    op_state_e         r_state;
    op_state_e         w_state_nxt;

    logic [DATA_W-1:0] r_op1;
    logic [DATA_W-1:0] r_op2;
    logic [SEL_W-1:0]  r_sel;
    logic [ADDR_W-1:0] r_rs1;
    logic [ADDR_W-1:0] r_rs2;
    logic              r_use_imm;

    logic [DATA_W-1:0] w_op1_nxt;
    logic [DATA_W-1:0] w_op2_nxt;
    logic [SEL_W-1:0]  w_sel_nxt;
    logic [ADDR_W-1:0] w_rs1_nxt;
    logic [ADDR_W-1:0] w_rs2_nxt;
    logic              w_use_imm_nxt;

    logic [DATA_W-1:0] w_arr_rd1;
    logic [DATA_W-1:0] w_arr_rd2;
    logic [DATA_W-1:0] w_src1;
    logic [DATA_W-1:0] w_src2;
    logic              w_issue;
    logic              w_stall;
    logic              w_wr_live;
    logic              w_refresh1;
    logic              w_refresh2;

    reg_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_reg_array (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (wr_en),
        .i_wr_addr  (wr_addr),
        .i_wr_data  (wr_data),
        .i_rd_addr1 (rs1),
        .o_rd_data1 (w_arr_rd1),
        .i_rd_addr2 (rs2),
        .o_rd_data2 (w_arr_rd2)
    );

    // Handshake
    assign op_valid  = (r_state == ST_FULL);
    assign id_ready  = !op_valid || ex_ready;
    assign w_issue   = id_valid && id_ready;
    assign w_stall   = op_valid && !ex_ready;

    // A write to a nonzero register is architecturally visible
    assign w_wr_live = wr_en && (wr_addr != '0);

    // Same-cycle bypass of the write-back onto the source reads
    assign w_src1 = (w_wr_live && (wr_addr == rs1)) ? wr_data : w_arr_rd1;
    assign w_src2 = (w_wr_live && (wr_addr == rs2)) ? wr_data : w_arr_rd2;

    // While stalled, held operands track writes to their latched sources
    assign w_refresh1 = w_stall && w_wr_live && (wr_addr == r_rs1);
    assign w_refresh2 = w_stall && w_wr_live && !r_use_imm && (wr_addr == r_rs2);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: begin
                if (w_issue) begin
                    w_state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (!w_issue && ex_ready) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            default: w_state_nxt = ST_EMPTY;
        endcase
    end

    // Operand-latch next values
    always_comb begin
        w_op1_nxt     = r_op1;
        w_op2_nxt     = r_op2;
        w_sel_nxt     = r_sel;
        w_rs1_nxt     = r_rs1;
        w_rs2_nxt     = r_rs2;
        w_use_imm_nxt = r_use_imm;
        if (w_issue) begin
            w_op1_nxt     = w_src1;
            w_op2_nxt     = use_imm ? imm : w_src2;
            w_sel_nxt     = sel_in;
            w_rs1_nxt     = rs1;
            w_rs2_nxt     = rs2;
            w_use_imm_nxt = use_imm;
        end else if (r_state == ST_FULL) begin
            if (w_refresh1) begin
                w_op1_nxt = wr_data;
            end
            if (w_refresh2) begin
                w_op2_nxt = wr_data;
            end
        end
    end

    // Operand-latch registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op1     <= '0;
            r_op2     <= '0;
            r_sel     <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_use_imm <= 1'b0;
        end else begin
            r_op1     <= w_op1_nxt;
            r_op2     <= w_op2_nxt;
            r_sel     <= w_sel_nxt;
            r_rs1     <= w_rs1_nxt;
            r_rs2     <= w_rs2_nxt;
            r_use_imm <= w_use_imm_nxt;
        end
    end

    assign OP_1    = r_op1;
    assign OP_2    = r_op2;
    assign ALU_Sel = r_sel;

endmodule
